// File: rtl/shot_game_pkg.sv
// Shared definitions for the basketball shot game sequencer: state encoding,
// screen geometry and common field widths.
package shot_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READY     = 3'd1,
        ST_FLIGHT    = 3'd2,
        ST_RESULT    = 3'd3,
        ST_NEXT      = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int COORD_W  = 10;
    localparam int SEC_W    = 6;
    localparam int PLAYER_W = 3;
    localparam int SHOTS_W  = 4;
    localparam int FRAME_W  = 16;

endpackage

// File: rtl/shot_game_ctrl_sec_countdown.sv
// Shot clock: a clk-cycle prescaler feeding a seconds down-counter that
// parks at zero instead of wrapping.
module sec_countdown
    import shot_game_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int START_S = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    output logic [SEC_W-1:0] sec,
    output logic             done
);

    localparam int                PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0]  START_L  = SEC_W'(START_S);

    logic [PRE_W-1:0] pre_q;
    logic [SEC_W-1:0] sec_q;

    // Prescale clk into seconds and count the shot clock down while running.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            pre_q <= '0;
            sec_q <= START_L;
        end else if (run && (sec_q != '0)) begin
            if (pre_q == PRE_LAST) begin
                pre_q <= '0;
                sec_q <= sec_q - SEC_W'(1);
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
        end
    end

    assign sec  = sec_q;
    assign done = (sec_q == '0);

endmodule

// File: rtl/shot_game_ctrl.sv
// Multi-player shot game sequencer: turn order, shot clock, make/miss
// classification from the ball trajectory, per-player scores and the
// kinematic-block reset.
module shot_game_ctrl
    import shot_game_pkg::*;
#(
    parameter int NUM_PLAYERS       = 2,
    parameter int SHOTS_PER_TURN    = 5,
    parameter int CLK_HZ            = 100_000_000,
    parameter int SHOT_CLOCK_S      = 24,
    parameter int HOOP_X_MIN        = 560,
    parameter int HOOP_X_MAX        = 600,
    parameter int HOOP_Y            = 200,
    parameter int FLOOR_Y           = 470,
    parameter int MAX_FLIGHT_FRAMES = 255,
    parameter int RESULT_FRAMES     = 60,
    parameter int POINTS            = 2,
    parameter int SCORE_W           = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           shoot,
    input  logic                           frame_tick,
    input  logic [COORD_W-1:0]             ball_x,
    input  logic [COORD_W-1:0]             ball_y,
    output logic                           kin_rst,
    output logic [SEC_W-1:0]               shot_sec,
    output logic [PLAYER_W-1:0]            cur_player,
    output logic [SHOTS_W-1:0]             shots_left,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic                           made_pulse,
    output logic                           miss_pulse,
    output logic                           game_over,
    output logic [2:0]                     state_o
);

    localparam logic [COORD_W-1:0]  X_MIN_L      = COORD_W'(HOOP_X_MIN);
    localparam logic [COORD_W-1:0]  X_MAX_L      = COORD_W'(HOOP_X_MAX);
    localparam logic [COORD_W-1:0]  HOOP_Y_L     = COORD_W'(HOOP_Y);
    localparam logic [COORD_W-1:0]  FLOOR_Y_L    = COORD_W'(FLOOR_Y);
    localparam logic [COORD_W-1:0]  X_EDGE_L     = COORD_W'(SCREEN_W - 1);
    localparam logic [FRAME_W-1:0]  MAX_FLIGHT_L = FRAME_W'(MAX_FLIGHT_FRAMES);
    localparam logic [FRAME_W-1:0]  RESULT_LAST  = FRAME_W'(RESULT_FRAMES - 1);
    localparam logic [SHOTS_W-1:0]  SHOTS_L      = SHOTS_W'(SHOTS_PER_TURN);
    localparam logic [PLAYER_W-1:0] LAST_PLAYER  = PLAYER_W'(NUM_PLAYERS - 1);

    state_t               state_q;
    logic                 start_q, shoot_q;
    logic                 kin_rst_q, made_q, miss_q, game_over_q;
    logic [PLAYER_W-1:0]  cur_player_q;
    logic [SHOTS_W-1:0]   shots_left_q;
    logic [FRAME_W-1:0]   frame_cnt_q;
    logic [COORD_W-1:0]   prev_y_q;
    logic [SCORE_W-1:0]   scores_q [NUM_PLAYERS];

    logic                 start_edge, shoot_edge;
    logic                 sec_load, sec_run, sec_done;
    logic [FRAME_W-1:0]   frame_cnt_nx;
    logic                 hit, lost;

    // Score add that sticks at the all-ones value instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + (SCORE_W+1)'(POINTS);
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    assign start_edge   = start & ~start_q;
    assign shoot_edge   = shoot & ~shoot_q;
    assign frame_cnt_nx = frame_cnt_q + FRAME_W'(1);

    assign hit  = (prev_y_q < HOOP_Y_L) && (ball_y >= HOOP_Y_L) &&
                  (ball_x >= X_MIN_L) && (ball_x <= X_MAX_L);
    assign lost = (ball_y >= FLOOR_Y_L) || (ball_x >= X_EDGE_L) ||
                  (frame_cnt_nx >= MAX_FLIGHT_L);

    assign sec_load = (((state_q == ST_IDLE) || (state_q == ST_GAME_OVER)) && start_edge) ||
                      (state_q == ST_NEXT);
    assign sec_run  = (state_q == ST_READY) && !shoot_edge;

    sec_countdown #(
        .CLK_HZ  (CLK_HZ),
        .START_S (SHOT_CLOCK_S)
    ) u_sec (
        .clk  (clk),
        .rst  (rst),
        .load (sec_load),
        .run  (sec_run),
        .sec  (shot_sec),
        .done (sec_done)
    );

    // Game sequencer: turn/shot bookkeeping, shot classification and scoring.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            start_q      <= start;
            shoot_q      <= shoot;
            kin_rst_q    <= 1'b1;
            made_q       <= 1'b0;
            miss_q       <= 1'b0;
            game_over_q  <= 1'b0;
            cur_player_q <= '0;
            shots_left_q <= SHOTS_L;
            frame_cnt_q  <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) scores_q[p] <= '0;
        end else begin
            start_q <= start;
            shoot_q <= shoot;
            made_q  <= 1'b0;
            miss_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    kin_rst_q <= 1'b1;
                    if (start_edge) begin
                        for (int p = 0; p < NUM_PLAYERS; p++) scores_q[p] <= '0;
                        state_q <= ST_READY;
                    end
                end
                ST_READY: begin
                    kin_rst_q <= 1'b1;
                    // A shot released on the cycle the clock expires still counts.
                    if (shoot_edge) begin
                        kin_rst_q   <= 1'b0;
                        prev_y_q    <= ball_y;
                        frame_cnt_q <= '0;
                        state_q     <= ST_FLIGHT;
                    end else if (sec_done) begin
                        miss_q      <= 1'b1;
                        frame_cnt_q <= '0;
                        state_q     <= ST_RESULT;
                    end
                end
                ST_FLIGHT: begin
                    if (frame_tick) begin
                        prev_y_q    <= ball_y;
                        frame_cnt_q <= frame_cnt_nx;
                        if (hit) begin
                            made_q      <= 1'b1;
                            frame_cnt_q <= '0;
                            state_q     <= ST_RESULT;
                            for (int p = 0; p < NUM_PLAYERS; p++)
                                if (PLAYER_W'(p) == cur_player_q) scores_q[p] <= sat_add(scores_q[p]);
                        end else if (lost) begin
                            miss_q      <= 1'b1;
                            frame_cnt_q <= '0;
                            state_q     <= ST_RESULT;
                        end
                    end
                end
                ST_RESULT: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == RESULT_LAST) begin
                            kin_rst_q <= 1'b1;
                            state_q   <= ST_NEXT;
                        end else begin
                            frame_cnt_q <= frame_cnt_nx;
                        end
                    end
                end
                ST_NEXT: begin
                    kin_rst_q <= 1'b1;
                    if (shots_left_q == SHOTS_W'(1)) begin
                        if (cur_player_q < LAST_PLAYER) begin
                            cur_player_q <= cur_player_q + PLAYER_W'(1);
                            shots_left_q <= SHOTS_L;
                            state_q      <= ST_READY;
                        end else begin
                            shots_left_q <= '0;
                            game_over_q  <= 1'b1;
                            state_q      <= ST_GAME_OVER;
                        end
                    end else begin
                        shots_left_q <= shots_left_q - SHOTS_W'(1);
                        state_q      <= ST_READY;
                    end
                end
                ST_GAME_OVER: begin
                    kin_rst_q   <= 1'b1;
                    game_over_q <= 1'b1;
                    if (start_edge) begin
                        for (int p = 0; p < NUM_PLAYERS; p++) scores_q[p] <= '0;
                        cur_player_q <= '0;
                        shots_left_q <= SHOTS_L;
                        game_over_q  <= 1'b0;
                        state_q      <= ST_READY;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_scores
        assign scores[p*SCORE_W +: SCORE_W] = scores_q[p];
    end

    assign kin_rst    = kin_rst_q;
    assign cur_player = cur_player_q;
    assign shots_left = shots_left_q;
    assign made_pulse = made_q;
    assign miss_pulse = miss_q;
    assign game_over  = game_over_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_shot_game_ctrl.sv
// Bench for shot_game_ctrl: a full two-player game, shot-clock expiry,
// shot-at-zero priority, score saturation and mid-flight reset.
module tb_shot_game_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, shoot, frame_tick;
    logic [9:0] ball_x, ball_y;

    logic       kin_rst, made_pulse, miss_pulse, game_over;
    logic [5:0] shot_sec;
    logic [2:0] cur_player, state_o;
    logic [3:0] shots_left;
    logic [15:0] scores;

    logic       s_kin_rst, s_made, s_miss, s_game_over;
    logic [5:0] s_shot_sec;
    logic [2:0] s_cur_player, s_state;
    logic [3:0] s_shots_left;
    logic [3:0] s_scores;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       made;
        logic       miss;
    } vec_t;

    typedef struct {
        string name;
        logic  made;
        logic  miss;
    } exp_t;

    vec_t vec [8];
    exp_t sb_q [$];

    always #5 clk = ~clk;

    shot_game_ctrl #(
        .NUM_PLAYERS(2), .SHOTS_PER_TURN(2), .CLK_HZ(10), .SHOT_CLOCK_S(24),
        .MAX_FLIGHT_FRAMES(20), .RESULT_FRAMES(2), .POINTS(2), .SCORE_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .shoot(shoot), .frame_tick(frame_tick),
        .ball_x(ball_x), .ball_y(ball_y), .kin_rst(kin_rst), .shot_sec(shot_sec),
        .cur_player(cur_player), .shots_left(shots_left), .scores(scores),
        .made_pulse(made_pulse), .miss_pulse(miss_pulse), .game_over(game_over),
        .state_o(state_o)
    );

    // Narrow-score copy driven by the same stimulus to expose saturation.
    shot_game_ctrl #(
        .NUM_PLAYERS(2), .SHOTS_PER_TURN(2), .CLK_HZ(10), .SHOT_CLOCK_S(24),
        .MAX_FLIGHT_FRAMES(20), .RESULT_FRAMES(2), .POINTS(2), .SCORE_W(2)
    ) u_sat (
        .clk(clk), .rst(rst), .start(start), .shoot(shoot), .frame_tick(frame_tick),
        .ball_x(ball_x), .ball_y(ball_y), .kin_rst(s_kin_rst), .shot_sec(s_shot_sec),
        .cur_player(s_cur_player), .shots_left(s_shots_left), .scores(s_scores),
        .made_pulse(s_made), .miss_pulse(s_miss), .game_over(s_game_over),
        .state_o(s_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},     32'(state_o), 32'd0);
        check({tag, "_scores"},    32'(scores), 32'd0);
        check({tag, "_player"},    32'(cur_player), 32'd0);
        check({tag, "_shotsleft"}, 32'(shots_left), 32'd2);
        check({tag, "_shotsec"},   32'(shot_sec), 32'd24);
        check({tag, "_kinrst"},    32'(kin_rst), 32'd1);
        check({tag, "_made"},      32'(made_pulse), 32'd0);
        check({tag, "_miss"},      32'(miss_pulse), 32'd0);
        check({tag, "_gameover"},  32'(game_over), 32'd0);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            check({e.name, "_made"}, 32'(made_pulse), 32'(e.made));
            check({e.name, "_miss"}, 32'(miss_pulse), 32'(e.miss));
        end
    endtask

    // Drive one frame with the given ball position; outputs checked one clock later.
    task automatic frame(input int idx);
        exp_t e;
        ball_x     = vec[idx].x;
        ball_y     = vec[idx].y;
        frame_tick = 1'b1;
        e.name = $sformatf("frame%0d", idx);
        e.made = vec[idx].made;
        e.miss = vec[idx].miss;
        sb_q.push_back(e);
        @(negedge clk);
        frame_tick = 1'b0;
        pop_check();
    endtask

    task automatic do_shoot();
        ball_x = 10'd100;
        ball_y = 10'd400;
        shoot  = 1'b1;
        @(negedge clk);
        shoot = 1'b0;
        check("shoot_state", 32'(state_o), 32'd2);
        check("shoot_kinrst", 32'(kin_rst), 32'd0);
    endtask

    task automatic fly(input int first, input int last);
        for (int i = first; i <= last; i++) frame(i);
        check("after_fly_state", 32'(state_o), 32'd3);
    endtask

    // Two frame ticks of RESULT, then one cycle of NEXT.
    task automatic result_hold(input logic [2:0] exp_state_after);
        for (int i = 0; i < 2; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            if (i == 0) @(negedge clk);
        end
        check("next_state", 32'(state_o), 32'd4);
        check("next_kinrst", 32'(kin_rst), 32'd1);
        @(negedge clk);
        check("after_next_state", 32'(state_o), 32'(exp_state_after));
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{10'd580, 10'd190, 1'b0, 1'b0};
        vec[1] = '{10'd580, 10'd205, 1'b1, 1'b0};
        vec[2] = '{10'd580, 10'd190, 1'b0, 1'b0};
        vec[3] = '{10'd580, 10'd205, 1'b1, 1'b0};
        vec[4] = '{10'd500, 10'd190, 1'b0, 1'b0};
        vec[5] = '{10'd500, 10'd205, 1'b0, 1'b0};
        vec[6] = '{10'd500, 10'd470, 1'b0, 1'b1};
        vec[7] = '{10'd639, 10'd100, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; shoot = 1'b0; frame_tick = 1'b0;
        ball_x = 10'd100; ball_y = 10'd400;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // shoot outside READY is ignored
        shoot = 1'b1;
        @(negedge clk);
        shoot = 1'b0;
        @(negedge clk);
        check("idle_shoot_ignored", 32'(state_o), 32'd0);

        // Shot clock expiry: 24 s at 10 cycles per second.
        start_pulse();
        for (int n = 0; n <= 240; n++) begin
            check("countdown_sec", 32'(shot_sec), 32'(24 - n / 10));
            check("countdown_state", 32'(state_o), 32'd1);
            check("countdown_nomiss", 32'(miss_pulse), 32'd0);
            @(negedge clk);
        end
        check("violation_miss", 32'(miss_pulse), 32'd1);
        check("violation_state", 32'(state_o), 32'd3);
        check("violation_score", 32'(scores), 32'd0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rst_after_violation");

        // Full game.
        start_pulse();
        check("g1_player", 32'(cur_player), 32'd0);
        check("g1_shotsleft", 32'(shots_left), 32'd2);
        do_shoot();
        fly(0, 1);
        check("g1_score", 32'(scores[7:0]), 32'd2);
        check("g1_sat_score", 32'(s_scores[1:0]), 32'd2);
        result_hold(3'd1);

        check("g2_player", 32'(cur_player), 32'd0);
        check("g2_shotsleft", 32'(shots_left), 32'd1);
        do_shoot();
        fly(2, 3);
        check("g2_score", 32'(scores[7:0]), 32'd4);
        check("g2_sat_score", 32'(s_scores[1:0]), 32'd3);
        result_hold(3'd1);

        check("g3_player", 32'(cur_player), 32'd1);
        check("g3_shotsleft", 32'(shots_left), 32'd2);
        do_shoot();
        fly(4, 6);
        check("g3_scores", 32'(scores), 32'h0004);
        result_hold(3'd1);

        check("g4_player", 32'(cur_player), 32'd1);
        check("g4_shotsleft", 32'(shots_left), 32'd1);
        begin : wait_zero
            int budget = 0;
            while (shot_sec != 6'd0 && budget < 400) begin
                @(negedge clk);
                budget++;
            end
            check("wait_zero_budget", 32'(shot_sec), 32'd0);
        end
        check("zero_state_ready", 32'(state_o), 32'd1);
        ball_x = 10'd100;
        ball_y = 10'd400;
        shoot  = 1'b1;
        @(negedge clk);
        shoot = 1'b0;
        check("zero_shot_state", 32'(state_o), 32'd2);
        check("zero_shot_nomiss", 32'(miss_pulse), 32'd0);
        fly(7, 7);
        result_hold(3'd5);
        check("over_flag", 32'(game_over), 32'd1);
        check("over_scores", 32'(scores), 32'h0004);
        check("over_kinrst", 32'(kin_rst), 32'd1);
        start_pulse();
        check("restart_state", 32'(state_o), 32'd1);
        check("restart_scores", 32'(scores), 32'd0);
        check("restart_player", 32'(cur_player), 32'd0);
        check("restart_shotsleft", 32'(shots_left), 32'd2);
        check("restart_gameover", 32'(game_over), 32'd0);

        // Reset in the middle of a flight.
        do_shoot();
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midflight_rst");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
